// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if : requester-side and memory-side bus bundle of mem_arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256
);
   // port 0 = dcache, port 1 = icache
   logic              m0_enable_i;
   logic              m0_write_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [DATA_W-1:0] m0_data_i;
   logic              m0_ack_o;
   logic [DATA_W-1:0] m0_data_o;

   logic              m1_enable_i;
   logic              m1_write_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [DATA_W-1:0] m1_data_i;
   logic              m1_ack_o;
   logic [DATA_W-1:0] m1_data_o;

   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_data_i;

   logic              timeout_o;

   // arbiter view
   modport master (
      input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
      input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
      input  mem_ack_i, mem_data_i,
      output m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output timeout_o
   );

   // environment view: cache engines and Data_Memory
   modport slave (
      output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
      output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
      output mem_ack_i, mem_data_i,
      input  m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  timeout_o
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter : two-port arbiter for the shared Data_Memory line port
//   Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break,
//   otherwise fixed priority to port 0).
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 256,
   parameter int TIMEOUT = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.master bus
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_GNT0 = 2'd1;
   localparam logic [1:0] c_GNT1 = 2'd2;

   localparam int                 c_CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_timeout;

   logic               w_gnt0;
   logic               w_gnt1;
   logic               w_req_any;
   logic               w_pick1;
   logic               w_own_en;
   logic               w_cnt_hit;
   logic               w_done;

   logic               w_mem_write;
   logic [ADDR_W-1:0]  w_mem_addr;
   logic [DATA_W-1:0]  w_mem_wdata;

   assign w_gnt0    = (r_state == c_GNT0);
   assign w_gnt1    = (r_state == c_GNT1);
   assign w_req_any = bus.m0_enable_i | bus.m1_enable_i;
   assign w_cnt_hit = (r_cnt == c_CNT_MAX);

`ifdef ARB_ROUND_ROBIN_EN
   // r_last = 1 when port 1 held the most recent grant; reset value lets port 0 win the first tie
   logic r_last;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_last <= 1'b1;
      end else if ((r_state == c_IDLE) && w_req_any) begin
         r_last <= w_pick1;
      end
   end

   assign w_pick1 = bus.m1_enable_i & (~bus.m0_enable_i | ~r_last);
`else
   assign w_pick1 = bus.m1_enable_i & ~bus.m0_enable_i;
`endif

   // Request-side mux from the granted port; everything reads as 0 in IDLE
   always_comb begin
      w_own_en    = 1'b0;
      w_mem_write = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      case (r_state)
         c_GNT0: begin
            w_own_en    = bus.m0_enable_i;
            w_mem_write = bus.m0_write_i;
            w_mem_addr  = bus.m0_addr_i;
            w_mem_wdata = bus.m0_data_i;
         end
         c_GNT1: begin
            w_own_en    = bus.m1_enable_i;
            w_mem_write = bus.m1_write_i;
            w_mem_addr  = bus.m1_addr_i;
            w_mem_wdata = bus.m1_data_i;
         end
         default: begin
            w_own_en    = 1'b0;
         end
      endcase
   end

   // Completion, withdrawal or timeout all end the grant
   assign w_done = bus.mem_ack_i | ~w_own_en | w_cnt_hit;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_req_any) begin
               w_state_nxt = w_pick1 ? c_GNT1 : c_GNT0;
            end
         end
         c_GNT0, c_GNT1: begin
            if (w_done) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: begin
            w_state_nxt = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= c_IDLE;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         // Withdrawal at the last count is not an abort, so enable gates the pulse
         r_timeout <= (w_gnt0 | w_gnt1) & w_own_en & ~bus.mem_ack_i & w_cnt_hit;
         if (r_state == c_IDLE) begin
            r_cnt <= '0;
         end else if (!w_cnt_hit) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.mem_enable_o = w_own_en;
   assign bus.mem_write_o  = w_mem_write;
   assign bus.mem_addr_o   = w_mem_addr;
   assign bus.mem_data_o   = w_mem_wdata;

   assign bus.m0_ack_o     = w_gnt0 & bus.mem_ack_i;
   assign bus.m0_data_o    = w_gnt0 ? bus.mem_data_i : '0;
   assign bus.m1_ack_o     = w_gnt1 & bus.mem_ack_i;
   assign bus.m1_data_o    = w_gnt1 ? bus.mem_data_i : '0;

   assign bus.timeout_o    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

   logic clk;
   logic rst_n;

   int   n_tests;
   int   n_fail;
   int   exp_last;
   int   win;

   logic [31:0]  win_addr;
   logic [31:0]  lose_addr;
   logic [255:0] d_a;
   logic [255:0] d_b;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus    ();
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus_to ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(64)) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(8)) u_dut_to (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus_to)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      exp_last = 1;
      d_a      = {8{32'h1111_0000}};
      d_b      = {8{32'h2222_0000}};

      rst_n = 1'b0;
      bus.m0_enable_i = 1'b0; bus.m0_write_i = 1'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
      bus.m1_enable_i = 1'b0; bus.m1_write_i = 1'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0;
      bus.mem_ack_i   = 1'b0; bus.mem_data_i = '0;
      bus_to.m0_enable_i = 1'b0; bus_to.m0_write_i = 1'b0; bus_to.m0_addr_i = '0; bus_to.m0_data_i = '0;
      bus_to.m1_enable_i = 1'b0; bus_to.m1_write_i = 1'b0; bus_to.m1_addr_i = '0; bus_to.m1_data_i = '0;
      bus_to.mem_ack_i   = 1'b0; bus_to.mem_data_i = '0;

      // reset state
      repeat (2) cyc();
      mid();
      check_eq("rst_mem_en",  bus.mem_enable_o, 0);
      check_eq("rst_mem_adr", bus.mem_addr_o,   0);
      check_eq("rst_ack0",    bus.m0_ack_o,     0);
      check_eq("rst_ack1",    bus.m1_ack_o,     0);
      check_eq("rst_tmo",     bus_to.timeout_o, 0);
      cyc(); rst_n = 1'b1;

      // single read on port 0, ack 10 cycles after grant
      cyc(); bus.m0_enable_i = 1'b1; bus.m0_addr_i = 32'h0000_0020;
      mid(); check_eq("rd_req_cycle_en", bus.mem_enable_o, 0);
      cyc(); mid();
      check_eq("rd_gnt_en",  bus.mem_enable_o, 1);
      check_eq("rd_gnt_adr", bus.mem_addr_o,   32'h20);
      check_eq("rd_gnt_wr",  bus.mem_write_o,  0);
      repeat (9) cyc();
      mid(); check_eq("rd_no_early_ack", bus.m0_ack_o, 0);
      cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = {64{4'h5}};
      mid();
      check_eq("rd_ack0",  bus.m0_ack_o,  1);
      check_eq("rd_data0", bus.m0_data_o, {64{4'h5}});
      check_eq("rd_ack1",  bus.m1_ack_o,  0);
      check_eq("rd_data1", bus.m1_data_o, 0);
      cyc(); bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; bus.m0_enable_i = 1'b0;
      mid();
      check_eq("rd_after_en",  bus.mem_enable_o, 0);
      check_eq("rd_after_ack", bus.m0_ack_o,     0);
      exp_last = 0;

      // simultaneous requests
`ifdef ARB_ROUND_ROBIN_EN
      win = (exp_last == 0) ? 1 : 0;
`else
      win = 0;
`endif
      win_addr  = (win == 0) ? 32'h0000_0100 : 32'h0000_0200;
      lose_addr = (win == 0) ? 32'h0000_0200 : 32'h0000_0100;
      cyc();
      bus.m0_enable_i = 1'b1; bus.m0_addr_i = 32'h0000_0100;
      bus.m1_enable_i = 1'b1; bus.m1_addr_i = 32'h0000_0200;
      mid(); check_eq("tie_idle_en", bus.mem_enable_o, 0);
      cyc(); mid();
      check_eq("tie_win_adr", bus.mem_addr_o,   win_addr);
      check_eq("tie_win_en",  bus.mem_enable_o, 1);
      cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = d_a;
      mid();
      check_eq("tie_win_ack",  (win == 0) ? bus.m0_ack_o  : bus.m1_ack_o,  1);
      check_eq("tie_win_data", (win == 0) ? bus.m0_data_o : bus.m1_data_o, d_a);
      check_eq("tie_lose_ack", (win == 0) ? bus.m1_ack_o  : bus.m0_ack_o,  0);
      cyc(); bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
      if (win == 0) bus.m0_enable_i = 1'b0; else bus.m1_enable_i = 1'b0;
      mid(); check_eq("tie_gap_en", bus.mem_enable_o, 0);
      cyc(); mid();
      check_eq("tie_lose_adr", bus.mem_addr_o,   lose_addr);
      check_eq("tie_lose_en",  bus.mem_enable_o, 1);
      cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = d_b;
      mid();
      check_eq("tie_lose_ack2",  (win == 0) ? bus.m1_ack_o  : bus.m0_ack_o,  1);
      check_eq("tie_lose_data2", (win == 0) ? bus.m1_data_o : bus.m0_data_o, d_b);
      check_eq("tie_win_ack2",   (win == 0) ? bus.m0_ack_o  : bus.m1_ack_o,  0);
      cyc(); bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
      bus.m0_enable_i = 1'b0; bus.m1_enable_i = 1'b0;
      mid(); check_eq("tie_end_en", bus.mem_enable_o, 0);
      exp_last = (win == 0) ? 1 : 0;

      // write pass-through on port 1
      cyc();
      bus.m1_enable_i = 1'b1; bus.m1_write_i = 1'b1;
      bus.m1_addr_i = 32'h0000_0400; bus.m1_data_i = {32{8'hA5}};
      mid(); check_eq("wr_idle_wr", bus.mem_write_o, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(); mid();
         check_eq("wr_mem_wr",   bus.mem_write_o, 1);
         check_eq("wr_mem_adr",  bus.mem_addr_o,  32'h400);
         check_eq("wr_mem_data", bus.mem_data_o,  {32{8'hA5}});
      end
      cyc(); bus.mem_ack_i = 1'b1;
      mid();
      check_eq("wr_ack1", bus.m1_ack_o,    1);
      check_eq("wr_ack0", bus.m0_ack_o,    0);
      check_eq("wr_hold", bus.mem_write_o, 1);
      cyc(); bus.mem_ack_i = 1'b0; bus.m1_enable_i = 1'b0; bus.m1_write_i = 1'b0;
      mid(); check_eq("wr_done_wr", bus.mem_write_o, 0);

      // timeout, TIMEOUT = 8
      cyc(); bus_to.m0_enable_i = 1'b1; bus_to.m0_addr_i = 32'h0000_0040;
      cyc(); mid();
      check_eq("to_gnt_en", bus_to.mem_enable_o, 1);
      repeat (6) cyc();
      cyc(); mid();
      check_eq("to_pre_pulse", bus_to.timeout_o,    0);
      check_eq("to_pre_en",    bus_to.mem_enable_o, 1);
      check_eq("to_pre_ack0",  bus_to.m0_ack_o,     0);
      cyc(); bus_to.m0_enable_i = 1'b0;
      mid();
      check_eq("to_pulse",  bus_to.timeout_o,    1);
      check_eq("to_idle",   bus_to.mem_enable_o, 0);
      check_eq("to_ack0",   bus_to.m0_ack_o,     0);
      check_eq("to_ack1",   bus_to.m1_ack_o,     0);
      cyc(); mid();
      check_eq("to_pulse_end", bus_to.timeout_o, 0);

      // withdrawal, then a stray ack in IDLE
      cyc(); bus.m1_enable_i = 1'b1; bus.m1_addr_i = 32'h0000_0600;
      cyc(); mid(); check_eq("wd_gnt_en", bus.mem_enable_o, 1);
      cyc(); bus.m1_enable_i = 1'b0;
      mid(); check_eq("wd_drop_en", bus.mem_enable_o, 0);
      cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = d_a;
      mid();
      check_eq("stray_ack1",  bus.m1_ack_o,  0);
      check_eq("stray_ack0",  bus.m0_ack_o,  0);
      check_eq("stray_data1", bus.m1_data_o, 0);
      check_eq("stray_data0", bus.m0_data_o, 0);
      cyc(); bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;

      // reset during GNT0
      cyc(); bus.m0_enable_i = 1'b1; bus.m0_addr_i = 32'h0000_0080;
      cyc(); bus.mem_ack_i = 1'b1; bus.mem_data_i = d_b;
      mid(); check_eq("rm_pre_ack0", bus.m0_ack_o, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rm_en",    bus.mem_enable_o, 0);
      check_eq("rm_adr",   bus.mem_addr_o,   0);
      check_eq("rm_ack0",  bus.m0_ack_o,     0);
      check_eq("rm_data0", bus.m0_data_o,    0);
      cyc(); bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; rst_n = 1'b1;
      mid(); check_eq("rm_rel_idle", bus.mem_enable_o, 0);
      cyc(); mid();
      check_eq("rm_regrant_en",  bus.mem_enable_o, 1);
      check_eq("rm_regrant_adr", bus.mem_addr_o,   32'h80);
      cyc(); bus.mem_ack_i = 1'b1;
      mid(); check_eq("rm_regrant_ack", bus.m0_ack_o, 1);
      cyc(); bus.mem_ack_i = 1'b0; bus.m0_enable_i = 1'b0;
      mid(); check_eq("rm_end_en", bus.mem_enable_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
